// File: rtl/ntt_transform_unit_if.sv
// Control/data bundle for ntt_transform_unit.
//   mode, start          : run request (mode 0 = forward, 1 = inverse), taken only when idle
//   done, busy           : completion pulse and in-progress flag
//   load_coeff/addr/data : coefficient write port
//   read_addr/read_data  : coefficient read port, one cycle of latency
// The master side drives requests and writes; the slave side is the transform engine.
interface ntt_transform_unit_if #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned ADDR_WIDTH = 8
);
  logic                  mode;
  logic                  start;
  logic                  done;
  logic                  busy;
  logic                  load_coeff;
  logic [ADDR_WIDTH-1:0] load_addr;
  logic [WIDTH-1:0]      load_data;
  logic [ADDR_WIDTH-1:0] read_addr;
  logic [WIDTH-1:0]      read_data;

  modport master (
    output mode, start, load_coeff, load_addr, load_data, read_addr,
    input  done, busy, read_data
  );

  modport slave (
    input  mode, start, load_coeff, load_addr, load_data, read_addr,
    output done, busy, read_data
  );
endinterface

// File: rtl/ntt_transform_unit.sv
// In-place N-point number-theoretic transform over Z_Q, forward or inverse per run.
// Ports:
//   clk  : clock, everything on the rising edge
//   rst  : synchronous active-high reset (coefficient memory is kept)
//   bus  : ntt_transform_unit_if slave (start/mode/done/busy, load port, registered read port)
// A run permutes the memory into bit-reversed order on the start edge, performs N/2*log2(N)
// Cooley-Tukey butterflies (one per cycle), and for an inverse run scales every word by N^-1.
module ntt_transform_unit #(
  parameter int unsigned N              = 256,
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned Q              = 8380417,
  parameter int unsigned ADDR_WIDTH     = 8,
  parameter int unsigned OMEGA          = 3073009,
  parameter int unsigned N_INV          = 8347681,
  parameter int unsigned REDUCTION_TYPE = 0
) (
  input logic                clk,
  input logic                rst,
  ntt_transform_unit_if.slave bus
);

  localparam int unsigned SW    = (ADDR_WIDTH > 1) ? $clog2(ADDR_WIDTH) : 1;
  localparam int unsigned PW    = 2 * WIDTH;
  localparam int unsigned MW    = PW + 1;
  localparam int unsigned LW    = PW + MW;
  localparam int unsigned QBits = $clog2(Q);
  localparam logic [WIDTH-1:0] QW = WIDTH'(Q);
  // Barrett constant floor(4^k / Q) with 2^k > Q, so every product a*b < 4^k.
  localparam logic [MW-1:0] Mu = (MW'(1) << (2 * QBits)) / MW'(Q);

  typedef enum logic [1:0] {StIdle, StRun, StScale, StDone} state_e;

  function automatic logic [WIDTH-1:0] mod_mul(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    logic [PW-1:0] p;
    logic [PW-1:0] qe;
    logic [PW-1:0] r;
    p = PW'(a) * PW'(b);
    if (REDUCTION_TYPE == 0) begin
      r = p % PW'(Q);
    end else begin
      // Estimated quotient is at most two short of the true one.
      qe = PW'((LW'(p) * LW'(Mu)) >> (2 * QBits));
      r  = p - qe * PW'(Q);
      if (r >= PW'(Q)) r = r - PW'(Q);
      if (r >= PW'(Q)) r = r - PW'(Q);
    end
    return WIDTH'(r);
  endfunction

  function automatic logic [WIDTH-1:0] pow_mod(input int unsigned e);
    logic [63:0]  r;
    logic [63:0]  b;
    int unsigned  k;
    r = 64'd1;
    b = 64'(OMEGA) % 64'(Q);
    k = e;
    for (int i = 0; i < 32; i++) begin
      if (k[0]) r = (r * b) % 64'(Q);
      b = (b * b) % 64'(Q);
      k = k >> 1;
    end
    return WIDTH'(r);
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] bitrev(input logic [ADDR_WIDTH-1:0] x);
    logic [ADDR_WIDTH-1:0] r;
    for (int k = 0; k < ADDR_WIDTH; k++) r[k] = x[ADDR_WIDTH-1-k];
    return r;
  endfunction

  // Twiddle table OMEGA^e, e = 0..N-1, fixed at elaboration.
  logic [WIDTH-1:0] tw_rom [N];
  for (genvar e = 0; e < N; e++) begin : g_tw
    localparam logic [WIDTH-1:0] TwVal = pow_mod(e);
    assign tw_rom[e] = TwVal;
  end

  state_e                state_q;
  logic                  mode_q;
  logic                  busy_q;
  logic                  done_q;
  logic [SW-1:0]         stage_q;
  logic [ADDR_WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0]      read_data_q;
  logic [WIDTH-1:0]      mem_q [N];
  logic [WIDTH-1:0]      mem_d [N];

  logic [ADDR_WIDTH-1:0] mask;
  logic [ADDR_WIDTH-1:0] bf;
  logic [ADDR_WIDTH-1:0] idx_i;
  logic [ADDR_WIDTH-1:0] idx_j;
  logic [ADDR_WIDTH-1:0] tw_exp;
  logic [WIDTH-1:0]      op_a;
  logic [WIDTH-1:0]      mul_x;
  logic [WIDTH-1:0]      mul_y;
  logic [WIDTH-1:0]      prod;
  logic [WIDTH:0]        sum;
  logic [WIDTH-1:0]      bf_hi;
  logic [WIDTH-1:0]      bf_lo;
  logic                  bf_last;
  logic                  stage_last;

  // Butterfly addressing: in stage s the half-size is 2^s; the counter's low s bits pick the
  // offset m inside a group, the rest pick the group, which is spread out by one bit.
  always_comb begin
    mask   = (ADDR_WIDTH'(1) << stage_q) - ADDR_WIDTH'(1);
    bf     = {1'b0, cnt_q[ADDR_WIDTH-2:0]};
    idx_i  = ((bf & ~mask) << 1) | (bf & mask);
    idx_j  = idx_i | (ADDR_WIDTH'(1) << stage_q);
    tw_exp = (bf & mask) << (SW'(ADDR_WIDTH - 1) - stage_q);
    if (mode_q) tw_exp = ADDR_WIDTH'(0) - tw_exp;  // OMEGA^(N-e) for the inverse
    op_a = mem_q[idx_i];
    // The multiplier is shared between butterflies and the final N^-1 scaling.
    if (state_q == StScale) begin
      mul_x = mem_q[cnt_q];
      mul_y = WIDTH'(N_INV);
    end else begin
      mul_x = mem_q[idx_j];
      mul_y = tw_rom[tw_exp];
    end
    prod  = mod_mul(mul_x, mul_y);
    sum   = {1'b0, op_a} + {1'b0, prod};
    bf_hi = (sum >= {1'b0, QW}) ? WIDTH'(sum - {1'b0, QW}) : WIDTH'(sum);
    bf_lo = (op_a >= prod) ? (op_a - prod) : WIDTH'({1'b0, op_a} + {1'b0, QW} - {1'b0, prod});
    bf_last    = &cnt_q[ADDR_WIDTH-2:0];
    stage_last = (stage_q == SW'(ADDR_WIDTH - 1));
  end

  always_comb begin
    mem_d = mem_q;
    if (!rst) begin
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            for (int k = 0; k < N; k++) mem_d[k] = mem_q[bitrev(ADDR_WIDTH'(k))];
            // A load on the start edge lands where its coefficient ends up after permuting.
            if (bus.load_coeff) mem_d[bitrev(bus.load_addr)] = bus.load_data;
          end else if (bus.load_coeff) begin
            mem_d[bus.load_addr] = bus.load_data;
          end
        end
        StRun: begin
          mem_d[idx_i] = bf_hi;
          mem_d[idx_j] = bf_lo;
        end
        StScale: mem_d[cnt_q] = prod;
        StDone: begin
          if (bus.load_coeff) mem_d[bus.load_addr] = bus.load_data;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      mode_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      stage_q     <= '0;
      cnt_q       <= '0;
      read_data_q <= '0;
    end else begin
      read_data_q <= mem_q[bus.read_addr];
      done_q      <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            state_q <= StRun;
            mode_q  <= bus.mode;
            busy_q  <= 1'b1;
            stage_q <= '0;
            cnt_q   <= '0;
          end
        end
        StRun: begin
          cnt_q <= cnt_q + ADDR_WIDTH'(1);
          if (bf_last) begin
            cnt_q <= '0;
            if (!stage_last) begin
              stage_q <= stage_q + SW'(1);
            end else if (mode_q) begin
              state_q <= StScale;
            end else begin
              state_q <= StDone;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        StScale: begin
          cnt_q <= cnt_q + ADDR_WIDTH'(1);
          if (&cnt_q) begin
            state_q <= StDone;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        StDone: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.read_data = read_data_q;

endmodule

// File: tb/tb_ntt_transform_unit.sv
// Self-checking bench for ntt_transform_unit: a direct O(N^2) DFT and a cyclic convolution
// serve as reference; transforms are driven through the load/start/read ports.
module tb_ntt_transform_unit;
  localparam int unsigned N     = 256;
  localparam int unsigned Q     = 8380417;
  localparam int unsigned OMEGA = 3073009;
  localparam int unsigned N_INV = 8347681;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ntt_transform_unit_if #(.WIDTH(32), .ADDR_WIDTH(8)) bus ();

  ntt_transform_unit #(
    .N(N), .WIDTH(32), .Q(Q), .ADDR_WIDTH(8), .OMEGA(OMEGA), .N_INV(N_INV),
    .REDUCTION_TYPE(0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int failures = 0;

  longint unsigned pw [N];
  logic [31:0] in_v [N];
  logic [31:0] exp_v [N];
  logic [31:0] got_v [N];
  logic [31:0] orig_v [N];

  function automatic longint unsigned mm(input longint unsigned a, input longint unsigned b);
    return (a * b) % Q;
  endfunction

  task automatic model_fwd();
    longint unsigned acc;
    for (int k = 0; k < N; k++) begin
      acc = 0;
      for (int j = 0; j < N; j++) acc = (acc + mm(in_v[j], pw[(j * k) % N])) % Q;
      exp_v[k] = 32'(acc);
    end
  endtask

  task automatic load_vec();
    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      bus.load_coeff = 1'b1;
      bus.load_addr  = 8'(k);
      bus.load_data  = in_v[k];
    end
    @(negedge clk);
    bus.load_coeff = 1'b0;
  endtask

  task automatic read_vec();
    for (int k = 0; k <= N; k++) begin
      @(negedge clk);
      if (k > 0) got_v[k-1] = bus.read_data;
      if (k < N) bus.read_addr = 8'(k);
    end
  endtask

  // Starts a run and counts cycles from the start cycle to the done pulse.
  task automatic run_xform(input logic md, input bit poke, output int lat,
                           output logic busy_first, output logic busy_last,
                           output logic done_next);
    @(negedge clk);
    bus.mode  = md;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start  = 1'b0;
    lat        = 1;
    busy_first = bus.busy;
    while (bus.done !== 1'b1 && lat < 3000) begin
      if (poke) begin
        bus.start      = 1'b1;
        bus.mode       = ~md;
        bus.load_coeff = 1'b1;
        bus.load_addr  = 8'($urandom);
        bus.load_data  = 32'($urandom_range(Q - 1));
      end
      @(negedge clk);
      lat++;
    end
    bus.start      = 1'b0;
    bus.load_coeff = 1'b0;
    busy_last      = bus.busy;
    @(negedge clk);
    done_next = bus.done;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy);
    end
    checks++;
    if (bus.done !== 1'b0) begin
      failures++; $display("FAIL reset_done got=%b exp=0", bus.done);
    end
    checks++;
    if (bus.read_data !== 32'd0) begin
      failures++; $display("FAIL reset_read_data got=%0d exp=0", bus.read_data);
    end
    rst = 1'b0;
  endtask

  // Forward transform of a fixed input; checks latency, handshake and every output word.
  task automatic fwd_case(input string name);
    int lat, bad, first;
    logic bf, bl, dn;
    model_fwd();
    load_vec();
    run_xform(1'b0, 1'b0, lat, bf, bl, dn);
    read_vec();
    checks++;
    if (lat != 1025) begin
      failures++; $display("FAIL %s_latency got=%0d exp=1025", name, lat);
    end
    checks++;
    if (bf !== 1'b1 || bl !== 1'b0 || dn !== 1'b0) begin
      failures++;
      $display("FAIL %s_handshake busy_first=%b busy_at_done=%b done_after=%b exp=1,0,0",
               name, bf, bl, dn);
    end
    bad = 0; first = 0;
    for (int k = 0; k < N; k++) if (got_v[k] !== exp_v[k]) begin
      if (bad == 0) first = k;
      bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL %s_data idx=%0d got=%0d exp=%0d bad=%0d", name, first, got_v[first],
               exp_v[first], bad);
    end
  endtask

  task automatic test_forward_delta();
    for (int k = 0; k < N; k++) in_v[k] = 0;
    in_v[0] = 1;
    fwd_case("fwd_delta");
    checks++;
    if (got_v[200] !== 32'd1) begin
      failures++; $display("FAIL fwd_delta_x200 got=%0d exp=1", got_v[200]);
    end
  endtask

  task automatic test_forward_const();
    for (int k = 0; k < N; k++) in_v[k] = 5;
    fwd_case("fwd_const");
    checks++;
    if (got_v[0] !== 32'd1280 || got_v[1] !== 32'd0) begin
      failures++; $display("FAIL fwd_const_x0x1 got=%0d,%0d exp=1280,0", got_v[0], got_v[1]);
    end
  endtask

  task automatic test_forward_x();
    for (int k = 0; k < N; k++) in_v[k] = 0;
    in_v[1] = 1;
    fwd_case("fwd_x");
    checks++;
    if (got_v[1] !== 32'd3073009 || got_v[128] !== 32'd8380416) begin
      failures++;
      $display("FAIL fwd_x_points got=%0d,%0d exp=3073009,8380416", got_v[1], got_v[128]);
    end
  endtask

  task automatic test_round_trip();
    int lat, bad, first;
    logic bf, bl, dn;
    for (int p = 0; p < 2; p++) begin
      for (int k = 0; k < N; k++) in_v[k] = (p == 0) ? 32'($urandom_range(Q - 1)) : Q - 1;
      orig_v = in_v;
      fwd_case((p == 0) ? "rt_rand_fwd" : "rt_qm1_fwd");
      in_v = got_v;
      load_vec();
      run_xform(1'b1, 1'b0, lat, bf, bl, dn);
      read_vec();
      checks++;
      if (lat != 1281 || bf !== 1'b1 || bl !== 1'b0 || dn !== 1'b0) begin
        failures++;
        $display("FAIL rt_inv_timing pat=%0d lat=%0d busy=%b,%b done_after=%b exp=1281,1,0,0",
                 p, lat, bf, bl, dn);
      end
      bad = 0; first = 0;
      for (int k = 0; k < N; k++) if (got_v[k] !== orig_v[k]) begin
        if (bad == 0) first = k;
        bad++;
      end
      checks++;
      if (bad != 0) begin
        failures++;
        $display("FAIL rt_data pat=%0d idx=%0d got=%0d exp=%0d bad=%0d", p, first,
                 got_v[first], orig_v[first], bad);
      end
    end
  endtask

  // Cyclic product through forward, pointwise multiply in the bench, inverse.
  task automatic test_poly_mul();
    logic [31:0] pa [N];
    logic [31:0] pb [N];
    logic [31:0] fa [N];
    longint unsigned r [N];
    int lat, bad, first;
    logic bf, bl, dn;
    for (int c = 0; c < 2; c++) begin
      for (int k = 0; k < N; k++) begin pa[k] = 0; pb[k] = 0; r[k] = 0; end
      if (c == 0) begin pa[0] = 1; pa[1] = 1; pb[0] = 1; pb[1] = 1; end
      else begin pa[255] = 1; pb[1] = 1; end
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) r[(i + j) % N] = (r[(i + j) % N] + mm(pa[i], pb[j])) % Q;
      in_v = pa; load_vec(); run_xform(1'b0, 1'b0, lat, bf, bl, dn); read_vec(); fa = got_v;
      in_v = pb; load_vec(); run_xform(1'b0, 1'b0, lat, bf, bl, dn); read_vec();
      for (int k = 0; k < N; k++) in_v[k] = 32'(mm(fa[k], got_v[k]));
      load_vec(); run_xform(1'b1, 1'b0, lat, bf, bl, dn); read_vec();
      bad = 0; first = 0;
      for (int k = 0; k < N; k++) if (got_v[k] !== 32'(r[k])) begin
        if (bad == 0) first = k;
        bad++;
      end
      checks++;
      if (bad != 0) begin
        failures++;
        $display("FAIL poly_mul case=%0d idx=%0d got=%0d exp=%0d bad=%0d", c, first,
                 got_v[first], r[first], bad);
      end
      checks++;
      if (got_v[0] !== 32'd1 || got_v[1] !== ((c == 0) ? 32'd2 : 32'd0)) begin
        failures++;
        $display("FAIL poly_mul_low case=%0d got=%0d,%0d", c, got_v[0], got_v[1]);
      end
    end
  endtask

  task automatic test_busy_ignored();
    int lat, bad, first;
    logic bf, bl, dn;
    for (int k = 0; k < N; k++) in_v[k] = 32'($urandom_range(Q - 1));
    model_fwd();
    load_vec();
    run_xform(1'b0, 1'b1, lat, bf, bl, dn);
    read_vec();
    checks++;
    if (lat != 1025 || dn !== 1'b0) begin
      failures++; $display("FAIL busy_ignore_latency got=%0d done_after=%b exp=1025,0", lat, dn);
    end
    bad = 0; first = 0;
    for (int k = 0; k < N; k++) if (got_v[k] !== exp_v[k]) begin
      if (bad == 0) first = k;
      bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL busy_ignore_data idx=%0d got=%0d exp=%0d bad=%0d", first, got_v[first],
               exp_v[first], bad);
    end
  endtask

  task automatic test_reset_mid_run();
    for (int k = 0; k < N; k++) in_v[k] = 32'($urandom_range(Q - 1));
    load_vec();
    @(negedge clk); bus.mode = 1'b0; bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    repeat (100) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      failures++; $display("FAIL mid_reset busy=%b done=%b exp=0,0", bus.busy, bus.done);
    end
    rst = 1'b0;
    for (int k = 0; k < N; k++) in_v[k] = 32'($urandom_range(Q - 1));
    fwd_case("after_reset");
  endtask

  initial begin
    bus.mode = 1'b0; bus.start = 1'b0; bus.load_coeff = 1'b0;
    bus.load_addr = '0; bus.load_data = '0; bus.read_addr = '0;
    pw[0] = 1;
    for (int k = 1; k < N; k++) pw[k] = mm(pw[k-1], OMEGA);
    test_reset();
    test_forward_delta();
    test_forward_const();
    test_forward_x();
    test_round_trip();
    test_poly_mul();
    test_busy_ignored();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ntt_transform_unit.md
Name: ntt_transform_unit

Overview:
- Single-memory, in-place N-point number-theoretic transform engine over Z_Q.
- Runs a forward or an inverse transform, selected per run.
- Used by the polynomial multiplier: forward on A and B, external pointwise multiply, then inverse.
- Contains its own combinational modular multiplier and twiddle table. Coefficients are loaded and read through simple address/data ports.

Parameters:
- N, 256, transform length (power of 2, ≥4).
- WIDTH, 32, coefficient width (≥ bits of Q).
- Q, 8380417, prime modulus, Q ≡ 1 mod N.
- ADDR_WIDTH, 8, log2(N).
- OMEGA, 3073009, primitive N-th root of unity mod Q.
- N_INV, 8347681, N^-1 mod Q.
- REDUCTION_TYPE, 0, multiplier reduction (0 = direct %, 1 = Barrett); results must be bit-identical.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- mode  in  1  sampled with start: 0 = forward, 1 = inverse.
- start  in  1  begin transform (accepted only when idle).
- done  out  1  one-cycle pulse at completion.
- busy  out  1  high while transforming.
- load_coeff  in  1  write strobe.
- load_addr  in  ADDR_WIDTH  write address.
- load_data  in  WIDTH  coefficient, must be < Q.
- read_addr  in  ADDR_WIDTH  read address.
- read_data  out  WIDTH  registered read data.

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high (rst).

Reset:
- FSM goes to IDLE; busy=0, done=0, read_data=0.
- Coefficient memory is not cleared.
- Reset mid-transform aborts immediately; memory contents are then undefined.

Interfaces:
- Load: when load_coeff=1 and not busy, mem[load_addr] <= load_data. Ignored while busy.
- Read: read_data <= mem[read_addr] every cycle (1-cycle latency). Value is don't-care while busy.

FSM:
- IDLE -> RUN on start (mode latched); start is ignored while busy.
- RUN executes butterflies, one per cycle.
- If inverse, RUN -> SCALE: N cycles, mem[k] <= mem[k]*N_INV mod Q.
- Then -> DONE (done=1 for one cycle, busy=0) -> IDLE.
- busy=1 from the cycle after start through the last RUN/SCALE cycle.
- Latency: forward, done asserts exactly log2(N)*N/2 + 1 cycles after the start cycle (1025 for N=256). Inverse adds N cycles (1281).

Transform definition:
- Output is in natural order.
- Forward: X[k] = Σ_j a[j]·OMEGA^(jk) mod Q.
- Inverse: a[j] = N_INV·Σ_k X[k]·OMEGA^(-jk) mod Q. Inverse(forward(a)) = a exactly.
- Implementation:
  - Bit-reverse permutation first (may be done in RUN or by addressing).
  - Then Cooley-Tukey DIT stages len = 2,4,…,N with twiddle OMEGA^((N/len)·m).
  - Inverse uses OMEGA^(N-e) in place of OMEGA^e.
  - Twiddle table: N entries OMEGA^e mod Q, computed at elaboration (constant function).
- Butterfly: t = w·B mod Q; A' = (A+t) mod Q; B' = (A−t+Q) mod Q. All outputs in [0, Q−1].
- Modular multiplier: result = (a·b) mod Q using a 2·WIDTH-bit product, for a, b < Q.
- Inputs ≥ Q: results undefined.

Test Plan:
- Forward delta: load a[0]=1, others 0, mode=0, start -> done after 1025 cycles; every read_data = 1.
- Forward constant: all a[j]=5 -> X[0]=1280, X[k]=0 for k≠0.
- Forward a[1]=1 only -> X[k]=OMEGA^k mod Q; X[1]=3073009, X[128]=Q−1=8380416.
- Round trip: random a[j]<Q, forward, read out, reload, inverse (done after 1281 cycles) -> read equals original a. Also repeat with all coefficients = Q−1.
- Polynomial product via external pointwise: A=1+x, B=1+x -> forward both, multiply pointwise, inverse -> result 1,2,1,0,…,0. Also x^255·x -> result[0]=1 (cyclic wrap).
- Control: start/load_coeff while busy ignored (memory and latency unchanged); rst mid-run -> busy=0, done=0 next cycle, new start accepted.
